wm_timer: RTL and testbench
===========================

WM_TIMER -- requirements
Module: wm_timer

Interface
REQ-001 Parameter BASE_CYC_PER_MIN, default 60, means clock cycles per minute at select code 00; the legal range is 2..2^20.
REQ-002 WMFSM_CLK  input  1  is the single clock; every register samples on its rising edge.
REQ-003 WMFSM_RST  input  1  is the reset: asynchronous, active-low.
REQ-004 clk_sel  input  2  is the clock-rate select: 00 = x1, 01 = x2, 10 = x4, 11 = x8 BASE_CYC_PER_MIN.
REQ-005 cnt_en  input  1  is count enable from the controller; 0 holds all counters.
REQ-006 cnt_done  input  1  is the synchronous clear request from the controller.
REQ-007 fsm_state  input  3  is the controller's current state, gray-coded per wm_pkg.
REQ-008 one_min  output  1  is high while at least 1 whole minute has elapsed since the last clear.
REQ-009 two_min  output  1  is high while at least 2 whole minutes have elapsed since the last clear.
REQ-010 five_min  output  1  is high while at least 5 whole minutes have elapsed since the last clear.
REQ-011 wash_count  output  2  is the number of wash phases entered in the current cycle.

Function
REQ-012 The terminal cycle count SHALL be (BASE_CYC_PER_MIN << sel_q) - 1, where sel_q is the registered clk_sel.
REQ-013 sel_q SHALL load clk_sel on every edge with cnt_done=1 and hold otherwise; clk_sel changes mid-interval are ignored.
REQ-014 cyc_cnt SHALL be wide enough for 8*BASE_CYC_PER_MIN-1, with no overflow.
REQ-015 Priority per edge SHALL be: cnt_done=1 clears cyc_cnt and min_cnt; else cnt_en=0 holds both; else counting proceeds.
REQ-016 While counting, cyc_cnt == terminal SHALL wrap cyc_cnt to 0 and increment min_cnt on the same edge; otherwise cyc_cnt increments.
REQ-017 min_cnt (3 bits) SHALL saturate at 5; once saturated, cyc_cnt continues to wrap but min_cnt does not change.
REQ-018 one_min, two_min and five_min SHALL be pure combinational decodes of registered min_cnt (>=1, >=2, ==5), with no added latency.
REQ-019 Consequently, exactly N*(terminal+1) enabled edges after a clear SHALL assert the N-minute flag.
REQ-020 prev_state SHALL register fsm_state every edge.
REQ-021 wash_count SHALL clear to 0 on any edge where fsm_state == IDLE.
REQ-022 wash_count SHALL increment on an edge where fsm_state == WASHING and prev_state != WASHING, saturating at 3.
REQ-023 In a wash cycle, the first wash entry SHALL make wash_count=1 and a double-wash re-entry from RINSING SHALL make it 2.
REQ-024 cnt_done and cnt_en both high SHALL resolve as a clear.
REQ-025 A clear on the wrap edge SHALL win, leaving min_cnt=0.
REQ-026 A pause (cnt_en=0) SHALL freeze cyc_cnt mid-minute; on resume, counting continues with no lost or extra cycles.
REQ-027 An unlisted fsm_state encoding SHALL leave wash_count unchanged.

Reset
REQ-028 WMFSM_RST low SHALL asynchronously force cyc_cnt=0, min_cnt=0, sel_q=00, prev_state=IDLE and wash_count=0.
REQ-029 Resulting output values during and after reset SHALL be one_min=0, two_min=0, five_min=0, wash_count=0.
REQ-030 Deassertion SHALL take effect at the first rising edge after release, with no extra startup cycles.
REQ-031 Reset asserted mid-minute SHALL discard all partial count.

Structure
REQ-032 Package wm_pkg SHALL hold the state encodings (IDLE 000, FILL 001, WASHING 011, RINSING 010, SPIN 110, PAUSE 111), the clk_sel codes, and the minute thresholds 1/2/5.
REQ-033 One sub-module, wm_min_prescaler, SHALL hold cyc_cnt, sel_q and the terminal compare, emitting a single-cycle min_tick.
REQ-034 min_cnt, the flag decode and wash_count SHALL reside in wm_timer itself.

Verification (BASE_CYC_PER_MIN=60)
REQ-035 sel=00, clear, then cnt_en=1 -> one_min rises after edge 60, two_min after edge 120, five_min after edge 300, and five_min holds at 600.
REQ-036 sel=11 latched via cnt_done, then count -> one_min after edge 480; changing clk_sel to 00 at edge 100 leaves one_min at edge 480.
REQ-037 Count 30 edges, cnt_en=0 for 50 edges, then resume -> one_min after 30 further enabled edges.
REQ-038 cnt_done=1 together with cnt_en=1 on edge 60 -> min_cnt=0 and one_min never asserts.
REQ-039 fsm_state sequence IDLE, FILL, WASHING, RINSING, WASHING, RINSING, SPIN, IDLE -> wash_count 0,0,1,1,2,2,2,0.
REQ-040 Assert WMFSM_RST low mid-minute with min_cnt=2 -> all outputs 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/wm_pkg.sv
// Shared encodings for the washing-machine timer slice: controller states,
// clock-rate select codes and the minute thresholds decoded by the timer.
package wm_pkg;

  // Controller states, gray-coded so adjacent phases differ by one bit.
  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    FILL    = 3'b001,
    WASHING = 3'b011,
    RINSING = 3'b010,
    SPIN    = 3'b110,
    PAUSE   = 3'b111
  } wm_state_e;

  // Clock-rate select: cycles per minute = BASE_CYC_PER_MIN << code.
  localparam logic [1:0] SEL_X1 = 2'b00;
  localparam logic [1:0] SEL_X2 = 2'b01;
  localparam logic [1:0] SEL_X4 = 2'b10;
  localparam logic [1:0] SEL_X8 = 2'b11;

  // Whole-minute thresholds for the elapsed-time flags.
  localparam logic [2:0] MIN_TH_ONE  = 3'd1;
  localparam logic [2:0] MIN_TH_TWO  = 3'd2;
  localparam logic [2:0] MIN_TH_FIVE = 3'd5;

endpackage

// File: rtl/wm_timer_if.sv
// Controller <-> timer signal bundle. There is no valid/ready handshake here:
// every input is sampled level-wise on each rising clock edge and every output
// is a continuous level; the controller (master) drives the select, enable,
// clear and state, the timer (slave) drives the flags, wash_count and the
// debug minute count.
interface wm_timer_if;
  logic [1:0] clk_sel;
  logic       cnt_en;
  logic       cnt_done;
  logic [2:0] fsm_state;
  logic       one_min;
  logic       two_min;
  logic       five_min;
  logic [1:0] wash_count;
  logic [2:0] dbg_min_cnt;

  modport master (
    output clk_sel, cnt_en, cnt_done, fsm_state,
    input  one_min, two_min, five_min, wash_count, dbg_min_cnt
  );

  modport slave (
    input  clk_sel, cnt_en, cnt_done, fsm_state,
    output one_min, two_min, five_min, wash_count, dbg_min_cnt
  );
endinterface

// File: rtl/wm_min_prescaler.sv
// Divides WMFSM_CLK down to one single-cycle min_tick per minute. The rate
// select is captured only on a clear so a running interval keeps its length.
module wm_min_prescaler #(
  parameter int unsigned BASE_CYC_PER_MIN = 60
) (
  input  logic       WMFSM_CLK,
  input  logic       WMFSM_RST,
  input  logic [1:0] clk_sel,
  input  logic       cnt_en,
  input  logic       cnt_done,
  output logic       min_tick
);
  import wm_pkg::*;

  // Wide enough to hold 8*BASE-1 at the slowest select.
  localparam int unsigned CW = $clog2(8 * BASE_CYC_PER_MIN);
  localparam logic [CW-1:0] BASE_W = CW'(BASE_CYC_PER_MIN);

  logic [CW-1:0] cyc_cnt;
  logic [1:0]    sel_q;
  logic [CW-1:0] terminal;

  assign terminal = (BASE_W << sel_q) - CW'(1);

  // Tick on the wrap edge; a clear or a pause suppresses it.
  assign min_tick = cnt_en && !cnt_done && (cyc_cnt == terminal);

  // Select latch plus cycle counter: clear beats hold beats count.
  always_ff @(posedge WMFSM_CLK or negedge WMFSM_RST) begin
    if (!WMFSM_RST) begin
      cyc_cnt <= '0;
      sel_q   <= SEL_X1;
    end else if (cnt_done) begin
      cyc_cnt <= '0;
      sel_q   <= clk_sel;
    end else if (cnt_en) begin
      if (cyc_cnt == terminal) begin
        cyc_cnt <= '0;
      end else begin
        cyc_cnt <= cyc_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/wm_timer.sv
// Washing-machine phase timer: counts whole minutes since the last clear,
// decodes the 1/2/5-minute flags and counts wash-phase entries per cycle.
module wm_timer #(
  parameter int unsigned BASE_CYC_PER_MIN = 60
) (
  input  logic     WMFSM_CLK,
  input  logic     WMFSM_RST,
  wm_timer_if.slave bus
);
  import wm_pkg::*;

  logic       min_tick;
  logic [2:0] min_cnt;
  logic [2:0] prev_state;
  logic [1:0] wash_count;

  wm_min_prescaler #(
    .BASE_CYC_PER_MIN(BASE_CYC_PER_MIN)
  ) u_prescaler (
    .WMFSM_CLK (WMFSM_CLK),
    .WMFSM_RST (WMFSM_RST),
    .clk_sel   (bus.clk_sel),
    .cnt_en    (bus.cnt_en),
    .cnt_done  (bus.cnt_done),
    .min_tick  (min_tick)
  );

  // Minute counter, saturating at five; clear wins over a coincident tick.
  always_ff @(posedge WMFSM_CLK or negedge WMFSM_RST) begin
    if (!WMFSM_RST) begin
      min_cnt <= '0;
    end else if (bus.cnt_done) begin
      min_cnt <= '0;
    end else if (min_tick && (min_cnt != MIN_TH_FIVE)) begin
      min_cnt <= min_cnt + 3'd1;
    end
  end

  // Wash-entry counter: reset in IDLE, bump on each fresh entry into WASHING.
  always_ff @(posedge WMFSM_CLK or negedge WMFSM_RST) begin
    if (!WMFSM_RST) begin
      prev_state <= IDLE;
      wash_count <= '0;
    end else begin
      prev_state <= bus.fsm_state;
      if (bus.fsm_state == IDLE) begin
        wash_count <= '0;
      end else if ((bus.fsm_state == WASHING) && (prev_state != WASHING)
                   && (wash_count != 2'd3)) begin
        wash_count <= wash_count + 2'd1;
      end
    end
  end

  assign bus.one_min     = (min_cnt >= MIN_TH_ONE);
  assign bus.two_min     = (min_cnt >= MIN_TH_TWO);
  assign bus.five_min    = (min_cnt == MIN_TH_FIVE);
  assign bus.wash_count  = wash_count;
  assign bus.dbg_min_cnt = min_cnt;

endmodule

// File: tb/tb_wm_timer.sv
// Directed bench for wm_timer at BASE_CYC_PER_MIN=60. Inputs change and
// outputs are sampled 1 time unit after each rising edge.
module tb_wm_timer;
  import wm_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  wm_timer_if bus ();

  wm_timer #(
    .BASE_CYC_PER_MIN(60)
  ) dut (
    .WMFSM_CLK (clk),
    .WMFSM_RST (rst_n),
    .bus       (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clear(input logic [1:0] sel);
    bus.clk_sel  = sel;
    bus.cnt_done = 1'b1;
    bus.cnt_en   = 1'b0;
    tick(1);
    bus.cnt_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.clk_sel   = SEL_X1;
    bus.cnt_en    = 1'b0;
    bus.cnt_done  = 1'b0;
    bus.fsm_state = IDLE;
    #2;
    checks++;
    if (bus.one_min !== 1'b0) begin errors++; $display("FAIL reset_one_min got=%b exp=0", bus.one_min); end
    checks++;
    if (bus.two_min !== 1'b0) begin errors++; $display("FAIL reset_two_min got=%b exp=0", bus.two_min); end
    checks++;
    if (bus.five_min !== 1'b0) begin errors++; $display("FAIL reset_five_min got=%b exp=0", bus.five_min); end
    checks++;
    if (bus.wash_count !== 2'd0) begin errors++; $display("FAIL reset_wash got=%0d exp=0", bus.wash_count); end
    tick(2);
    #3 rst_n = 1'b1;
    tick(1);
    checks++;
    if (bus.dbg_min_cnt !== 3'd0) begin errors++; $display("FAIL reset_min_cnt got=%0d exp=0", bus.dbg_min_cnt); end
  endtask

  task automatic test_minutes();
    do_clear(SEL_X1);
    bus.cnt_en = 1'b1;
    tick(59);
    checks++;
    if (bus.one_min !== 1'b0) begin errors++; $display("FAIL min_edge59 got=%b exp=0", bus.one_min); end
    tick(1);
    checks++;
    if (bus.one_min !== 1'b1) begin errors++; $display("FAIL min_edge60 got=%b exp=1", bus.one_min); end
    tick(59);
    checks++;
    if (bus.two_min !== 1'b0) begin errors++; $display("FAIL min_edge119 got=%b exp=0", bus.two_min); end
    tick(1);
    checks++;
    if (bus.two_min !== 1'b1) begin errors++; $display("FAIL min_edge120 got=%b exp=1", bus.two_min); end
    tick(179);
    checks++;
    if ({bus.five_min, bus.dbg_min_cnt} !== {1'b0, 3'd4}) begin
      errors++; $display("FAIL min_edge299 got=%b/%0d exp=0/4", bus.five_min, bus.dbg_min_cnt);
    end
    tick(1);
    checks++;
    if (bus.five_min !== 1'b1) begin errors++; $display("FAIL min_edge300 got=%b exp=1", bus.five_min); end
    tick(300);
    checks++;
    if ({bus.five_min, bus.dbg_min_cnt} !== {1'b1, 3'd5}) begin
      errors++; $display("FAIL min_edge600 got=%b/%0d exp=1/5", bus.five_min, bus.dbg_min_cnt);
    end
    bus.cnt_en = 1'b0;
  endtask

  task automatic test_sel_latch();
    do_clear(SEL_X8);
    bus.cnt_en = 1'b1;
    tick(100);
    bus.clk_sel = SEL_X1;
    tick(379);
    checks++;
    if (bus.one_min !== 1'b0) begin errors++; $display("FAIL sel_edge479 got=%b exp=0", bus.one_min); end
    tick(1);
    checks++;
    if ({bus.one_min, bus.dbg_min_cnt} !== {1'b1, 3'd1}) begin
      errors++; $display("FAIL sel_edge480 got=%b/%0d exp=1/1", bus.one_min, bus.dbg_min_cnt);
    end
    bus.cnt_en = 1'b0;
  endtask

  task automatic test_pause();
    do_clear(SEL_X1);
    bus.cnt_en = 1'b1;
    tick(30);
    bus.cnt_en = 1'b0;
    tick(50);
    checks++;
    if (bus.one_min !== 1'b0) begin errors++; $display("FAIL pause_hold got=%b exp=0", bus.one_min); end
    bus.cnt_en = 1'b1;
    tick(29);
    checks++;
    if (bus.one_min !== 1'b0) begin errors++; $display("FAIL pause_resume29 got=%b exp=0", bus.one_min); end
    tick(1);
    checks++;
    if (bus.one_min !== 1'b1) begin errors++; $display("FAIL pause_resume30 got=%b exp=1", bus.one_min); end
    bus.cnt_en = 1'b0;
  endtask

  task automatic test_clear_on_wrap();
    do_clear(SEL_X1);
    bus.cnt_en = 1'b1;
    tick(59);
    bus.cnt_done = 1'b1;
    tick(1);
    bus.cnt_done = 1'b0;
    checks++;
    if ({bus.one_min, bus.dbg_min_cnt} !== {1'b0, 3'd0}) begin
      errors++; $display("FAIL wrap_clear got=%b/%0d exp=0/0", bus.one_min, bus.dbg_min_cnt);
    end
    tick(59);
    checks++;
    if (bus.one_min !== 1'b0) begin errors++; $display("FAIL wrap_after59 got=%b exp=0", bus.one_min); end
    tick(1);
    checks++;
    if (bus.one_min !== 1'b1) begin errors++; $display("FAIL wrap_after60 got=%b exp=1", bus.one_min); end
    bus.cnt_en = 1'b0;
    do_clear(SEL_X1);
  endtask

  task automatic test_wash();
    logic [2:0] seq_a [8];
    logic [1:0] exp_a [8];
    logic [2:0] seq_b [9];
    logic [1:0] exp_b [9];
    seq_a = '{IDLE, FILL, WASHING, RINSING, WASHING, RINSING, SPIN, IDLE};
    exp_a = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0};
    // Saturation at 3 and unlisted encodings 100/101 holding the count.
    seq_b = '{WASHING, 3'b100, RINSING, WASHING, 3'b101, WASHING, RINSING, WASHING, RINSING};
    exp_b = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 8; i++) begin
      bus.fsm_state = seq_a[i];
      tick(1);
      checks++;
      if (bus.wash_count !== exp_a[i]) begin
        errors++; $display("FAIL wash_seq[%0d] got=%0d exp=%0d", i, bus.wash_count, exp_a[i]);
      end
    end
    for (int i = 0; i < 9; i++) begin
      bus.fsm_state = seq_b[i];
      tick(1);
      checks++;
      if (bus.wash_count !== exp_b[i]) begin
        errors++; $display("FAIL wash_sat[%0d] got=%0d exp=%0d", i, bus.wash_count, exp_b[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    // wash_count is 3 from the previous test; leave state SPIN so it holds.
    bus.fsm_state = SPIN;
    do_clear(SEL_X1);
    bus.cnt_en = 1'b1;
    tick(125);
    checks++;
    if ({bus.two_min, bus.dbg_min_cnt} !== {1'b1, 3'd2}) begin
      errors++; $display("FAIL rst_pre got=%b/%0d exp=1/2", bus.two_min, bus.dbg_min_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.one_min, bus.two_min, bus.five_min, bus.wash_count} !== 5'b0) begin
      errors++;
      $display("FAIL rst_async got=%b%b%b/%0d exp=000/0", bus.one_min, bus.two_min, bus.five_min, bus.wash_count);
    end
    tick(1);
    #3 rst_n = 1'b1;
    tick(59);
    checks++;
    if (bus.one_min !== 1'b0) begin errors++; $display("FAIL rst_restart59 got=%b exp=0", bus.one_min); end
    tick(1);
    checks++;
    if (bus.one_min !== 1'b1) begin errors++; $display("FAIL rst_restart60 got=%b exp=1", bus.one_min); end
    bus.cnt_en = 1'b0;
  endtask

  // Sequencer and final report
  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_minutes();
    test_sel_latch();
    test_pause();
    test_clear_on_wrap();
    test_wash();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
